decoder_mul_share_arb: RTL



---
 rtl/decoder_mul_share_arb_pkg.sv | 14 +
 rtl/decoder_mul_16s_12ns_26_1_1.sv | 22 ++
 rtl/decoder_rr_arb.sv | 32 +++
 rtl/decoder_mul_share_arb.sv | 87 ++++++++
 4 files changed

// File: rtl/decoder_mul_share_arb_pkg.sv
// Shared widths and helpers for the shared-multiplier arbiter.
package decoder_mul_share_arb_pkg;

    localparam int DIN0_W = 16;
    localparam int DIN1_W = 12;
    localparam int DOUT_W = 26;
    localparam int FULL_W = DIN0_W + DIN1_W;

    // Width of a binary index able to address n requesters (minimum 1 bit).
    function automatic int clog2_fn(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/decoder_mul_16s_12ns_26_1_1.sv
// Combinational 16-bit signed x 12-bit unsigned multiplier, low 26 bits kept.
module decoder_mul_16s_12ns_26_1_1
    import decoder_mul_share_arb_pkg::*;
(
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    output logic [DOUT_W-1:0] dout
);

    logic signed [FULL_W-1:0] w_a;
    logic signed [FULL_W-1:0] w_b;
    logic signed [FULL_W-1:0] w_full;

    // Extend both operands to the full product width so the multiply is exact.
    always_comb begin
        w_a    = {{DIN1_W{din0[DIN0_W-1]}}, din0};
        w_b    = {{DIN0_W{1'b0}}, din1};
        w_full = w_a * w_b;
        dout   = w_full[DOUT_W-1:0];
    end

endmodule

// File: rtl/decoder_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted requester.
module decoder_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic w_found;
    int   w_cand;

    // First asserted request in rotating order wins; nothing granted when disabled.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(i_last_grant) + k) % NUM_REQ;
            if (i_en && !w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = ID_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/decoder_mul_share_arb.sv
// One multiplier shared round-robin among NUM_REQ requesters, single output slot.
module decoder_mul_share_arb
    import decoder_mul_share_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_fn(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DIN0_W-1:0]   req_din0,
    input  logic [NUM_REQ*DIN1_W-1:0]   req_din1,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DOUT_W-1:0]           res_dout,
    output logic [ID_W-1:0]             res_id
);

    logic              r_res_valid;
    logic [DOUT_W-1:0] r_res_dout;
    logic [ID_W-1:0]   r_res_id;
    logic [ID_W-1:0]   r_last_grant;

    logic               w_free;
    logic               w_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_xfer;
    logic [DIN0_W-1:0]  w_din0;
    logic [DIN1_W-1:0]  w_din1;
    logic [DOUT_W-1:0]  w_prod;

    // The slot can take a new product when empty or being drained this cycle.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        w_free = !r_res_valid || res_ready;
        w_en   = w_free && !ap_rst;
        w_xfer = |w_grant;
    end

    decoder_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .i_en         (w_en),
        .o_grant      (w_grant),
        .o_idx        (w_idx)
    );

    // Route the winner's operands to the single multiplier.
    always_comb begin
        w_din0 = req_din0[int'(w_idx)*DIN0_W +: DIN0_W];
        w_din1 = req_din1[int'(w_idx)*DIN1_W +: DIN1_W];
    end

    decoder_mul_16s_12ns_26_1_1 u_mul (
        .din0 (w_din0),
        .din1 (w_din1),
        .dout (w_prod)
    );

    // Output slot and round-robin pointer; data/id hold when the slot just drains.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_res_valid  <= 1'b0;
            r_res_dout   <= '0;
            r_res_id     <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_res_valid  <= 1'b1;
            r_res_dout   <= w_prod;
            r_res_id     <= w_idx;
            r_last_grant <= w_idx;
        end else if (res_ready) begin
            r_res_valid  <= 1'b0;
        end
    end

    assign req_ready = w_grant;
    assign res_valid = r_res_valid;
    assign res_dout  = r_res_dout;
    assign res_id    = r_res_id;

endmodule
